// File: rtl/mau_pkg.sv
// Shared types and defaults for the memory access unit (MAR/MDR + memory handshake).
package mau_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mau_state_e;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/mem_access_unit.sv
// MAR/MDR holder running single read/write transactions over a req/ack handshake
// with timeout; sources MDR onto the A and M buses through zero-when-idle gates.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] S_bus,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              mda_oe,
  input  logic              mdm_oe,
  output logic [DATA_W-1:0] MDA_out,
  output logic [DATA_W-1:0] MDM_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  mau_state_e        state;
  logic              op;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [CW-1:0]     cnt;

  // cnt holds the 1-based index of the current ACCESS cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op    <= OP_RD;
      mar   <= '0;
      mdr   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_mar) mar <= S_bus[ADDR_W-1:0];
          if (ld_mdr) mdr <= S_bus;
          if (rd_req && wr_req) begin
            err  <= 1'b1;
            done <= 1'b1;
          end else if (rd_req || wr_req) begin
            state <= ACCESS;
            op    <= wr_req ? OP_WR : OP_RD;
            err   <= 1'b0;
            cnt   <= CW'(1);
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (op == OP_RD) mdr <= mem_rdata;
            state <= DONE;
            done  <= 1'b1;
            cnt   <= '0;
          end else if (cnt == CW'(TIMEOUT)) begin
            err   <= 1'b1;
            state <= DONE;
            done  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // decoded straight from the state register so reset drops mem_req without a clock
  assign mem_req   = (state == ACCESS);
  assign mem_we    = mem_req & op;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign busy      = (state != IDLE);
  assign MDA_out   = mda_oe ? mdr : '0;
  assign MDM_out   = mdm_oe ? mdr : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scenarios plus randomized traffic checked every cycle against a transaction-level model.
module tb_mem_access_unit;
  localparam int DW = 16, AW = 16, TO = 15;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] S_bus = '0, mem_rdata = '0;
  logic          ld_mar = 0, ld_mdr = 0, rd_req = 0, wr_req = 0, mda_oe = 0, mdm_oe = 0, mem_ack = 0;
  logic [DW-1:0] MDA_out, MDM_out, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_req, mem_we, busy, done, err;
  int            checks = 0, passes = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .S_bus(S_bus), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .rd_req(rd_req), .wr_req(wr_req), .mda_oe(mda_oe), .mdm_oe(mdm_oe),
    .MDA_out(MDA_out), .MDM_out(MDM_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: phase 0 idle, 1 waiting on memory, 2 completion cycle.
  // 'left' is the remaining ack budget of the outstanding transaction.
  int            ph, left;
  logic          mop, merr, mdone;
  logic [AW-1:0] mmar;
  logic [DW-1:0] mmdr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 0; left <= 0; mop <= 0; merr <= 0; mdone <= 0; mmar <= '0; mmdr <= '0;
    end else begin
      mdone <= 1'b0;
      if (ph == 0) begin
        if (ld_mar) mmar <= S_bus[AW-1:0];
        if (ld_mdr) mmdr <= S_bus;
        if (rd_req && wr_req) begin
          merr <= 1'b1; mdone <= 1'b1;
        end else if (rd_req || wr_req) begin
          ph <= 1; mop <= wr_req; merr <= 1'b0; left <= TO;
        end
      end else if (ph == 1) begin
        if (mem_ack) begin
          if (!mop) mmdr <= mem_rdata;
          ph <= 2; mdone <= 1'b1;
        end else if (left == 1) begin
          merr <= 1'b1; ph <= 2; mdone <= 1'b1;
        end else begin
          left <= left - 1;
        end
      end else begin
        ph <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_req", {31'd0, mem_req}, {31'd0, ph == 1});
      chk("m_busy", {31'd0, busy}, {31'd0, ph != 0});
      chk("m_done", {31'd0, done}, {31'd0, mdone});
      chk("m_err", {31'd0, err}, {31'd0, merr});
      chk("m_mda", {16'd0, MDA_out}, {16'd0, mda_oe ? mmdr : 16'h0});
      chk("m_mdm", {16'd0, MDM_out}, {16'd0, mdm_oe ? mmdr : 16'h0});
      if (ph == 1) begin
        chk("m_we", {31'd0, mem_we}, {31'd0, mop});
        chk("m_addr", {16'd0, mem_addr}, {16'd0, mmar});
        if (mop) chk("m_wdata", {16'd0, mem_wdata}, {16'd0, mmdr});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    // reset with both enables high
    mda_oe = 1; mdm_oe = 1;
    repeat (3) @(negedge clk);
    chk("rst_mda", {16'd0, MDA_out}, 32'h0);
    chk("rst_mdm", {16'd0, MDM_out}, 32'h0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'h0);
    #2 rst_n = 1;
    tick(); mdm_oe = 0; ld_mdr = 1; S_bus = 16'hA5A5;
    tick(); ld_mdr = 0;
    @(negedge clk);
    chk("mda_on", {16'd0, MDA_out}, 32'hA5A5);
    chk("mdm_off", {16'd0, MDM_out}, 32'h0);
    mda_oe = 0; #1;
    chk("mda_off", {16'd0, MDA_out}, 32'h0);

    // zero-wait read
    tick(); ld_mar = 1; S_bus = 16'h0010; mdm_oe = 1;
    tick(); ld_mar = 0; rd_req = 1;
    tick(); rd_req = 0; mem_ack = 1; mem_rdata = 16'h1234;
    @(negedge clk);
    chk("zw_req", {31'd0, mem_req}, 32'd1);
    chk("zw_addr", {16'd0, mem_addr}, 32'h0010);
    tick(); mem_ack = 0;
    @(negedge clk);
    chk("zw_done", {31'd0, done}, 32'd1);
    chk("zw_mdr", {16'd0, MDM_out}, 32'h1234);
    chk("zw_err", {31'd0, err}, 32'd0);
    tick();
    @(negedge clk);
    chk("zw_idle", {31'd0, busy}, 32'd0);

    // write, 3 wait states
    tick(); ld_mar = 1; S_bus = 16'h00FF;
    tick(); ld_mar = 0; ld_mdr = 1; S_bus = 16'hBEEF;
    tick(); ld_mdr = 0; wr_req = 1;
    tick(); wr_req = 0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      @(negedge clk);
      if (mem_req && mem_we && mem_addr == 16'h00FF && mem_wdata == 16'hBEEF) n++;
      tick();
    end
    mem_ack = 0;
    chk("wr_req_cycles", n, 32'd4);
    @(negedge clk);
    chk("wr_done", {31'd0, done}, 32'd1);
    chk("wr_req_low", {31'd0, mem_req}, 32'd0);
    wait_idle();

    // timeout
    tick(); rd_req = 1; mda_oe = 1;
    tick(); rd_req = 0;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (mem_req) n++;
      if (done) break;
      tick();
    end
    chk("to_cycles", n, 32'd15);
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_mdr", {16'd0, MDA_out}, 32'hBEEF);
    wait_idle();
    tick(); rd_req = 1; mem_rdata = 16'h5555;
    tick(); rd_req = 0; mem_ack = 1;
    @(negedge clk);
    chk("to_errclr", {31'd0, err}, 32'd0);
    tick(); mem_ack = 0;
    wait_idle();

    // collision
    tick(); rd_req = 1; wr_req = 1;
    tick(); rd_req = 0; wr_req = 0;
    @(negedge clk);
    chk("col_req", {31'd0, mem_req}, 32'd0);
    chk("col_err", {31'd0, err}, 32'd1);
    chk("col_done", {31'd0, done}, 32'd1);

    // ld_mdr ignored during a write access
    tick(); wr_req = 1;
    tick(); wr_req = 0; ld_mdr = 1; S_bus = 16'h7777;
    tick(); ld_mdr = 0; mem_ack = 1;
    @(negedge clk);
    chk("frz_wdata", {16'd0, mem_wdata}, 32'h5555);
    tick(); mem_ack = 0;
    wait_idle();
    @(negedge clk);
    chk("frz_mdr", {16'd0, MDA_out}, 32'h5555);

    // load + request in the same cycle
    tick(); ld_mar = 1; S_bus = 16'h0042; rd_req = 1;
    tick(); ld_mar = 0; rd_req = 0; mem_ack = 1; mem_rdata = 16'h0BAD;
    @(negedge clk);
    chk("same_addr", {16'd0, mem_addr}, 32'h0042);
    tick(); mem_ack = 0;
    wait_idle();

    // async reset in the 2nd cycle of a long read
    tick(); rd_req = 1;
    tick(); rd_req = 0;
    tick();
    #2 rst_n = 0; #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_mdr", {16'd0, MDA_out}, 32'h0);
    @(negedge clk); #2 rst_n = 1;
    tick();
    @(negedge clk);
    chk("arst_idle", {31'd0, busy}, 32'd0);
    chk("arst_mdr2", {16'd0, MDA_out}, 32'h0);

    // randomized traffic; ack density varies so timeouts also occur
    for (int blk = 0; blk < 12; blk++) begin
      int ack_div;
      ack_div = (blk % 3 == 2) ? 40 : (blk % 3 == 1) ? 6 : 2;
      for (int c = 0; c < 250; c++) begin
        tick();
        S_bus     = DW'($urandom);
        mem_rdata = DW'($urandom);
        ld_mar    = ($urandom_range(3) == 0);
        ld_mdr    = ($urandom_range(3) == 0);
        rd_req    = ($urandom_range(5) == 0);
        wr_req    = ($urandom_range(5) == 0);
        mda_oe    = $urandom_range(1) == 1;
        mdm_oe    = $urandom_range(1) == 1;
        mem_ack   = ($urandom_range(ack_div - 1) == 0);
      end
    end
    tick();
    rd_req = 0; wr_req = 0; ld_mar = 0; ld_mdr = 0; mem_ack = 0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access unit holding the memory address register (MAR) and memory data register (MDR) of the 16-bit datapath. It loads MAR/MDR from the S bus, runs single read/write transactions to main memory over a req/ack handshake with timeout, and sources the MDR onto the A bus (`MDA_out`) and M bus (`MDM_out`) through gated, zero-when-idle outputs. It sits directly upstream of the bus block and feeds its MDR inputs.

## Interface
Parameters:
- `DATA_W`, 16, data and bus width
- `ADDR_W`, 16, memory address width
- `TIMEOUT`, 15, maximum ACCESS cycles waiting for `mem_ack` (≥1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `S_bus`  in  DATA_W  shifter/ALU result bus, load source
- `ld_mar`  in  1  load MAR ← S_bus[ADDR_W-1:0]
- `ld_mdr`  in  1  load MDR ← S_bus
- `rd_req`  in  1  start read, single-cycle pulse
- `wr_req`  in  1  start write, single-cycle pulse
- `mda_oe`  in  1  drive MDR on `MDA_out`
- `mdm_oe`  in  1  drive MDR on `MDM_out`
- `MDA_out`  out  DATA_W  MDR when `mda_oe`, else 0
- `MDM_out`  out  DATA_W  MDR when `mdm_oe`, else 0
- `mem_req`  out  1  transaction request to main memory
- `mem_we`  out  1  1 = write, valid while `mem_req`
- `mem_addr`  out  ADDR_W  MAR, valid while `mem_req`
- `mem_wdata`  out  DATA_W  MDR, valid while `mem_req && mem_we`
- `mem_rdata`  in  DATA_W  read data, sampled when `mem_ack`
- `mem_ack`  in  1  memory completion
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky error flag

## Operation
- Reset: state IDLE; MAR, MDR, timeout counter = 0; `mem_req`, `mem_we`, `done`, `err`, `busy` = 0; `mem_addr`, `mem_wdata` = 0.
- States: IDLE, ACCESS, DONE.
- IDLE: `ld_mar`/`ld_mdr` update registers at the edge. Exactly one of `rd_req`/`wr_req` → ACCESS, `err` cleared, op latched. Both asserted → stay IDLE, set `err`, `done` pulses next cycle.
- ACCESS: `mem_req`=1, `mem_we`=op, `mem_addr`=MAR, `mem_wdata`=MDR. On `mem_ack`: read captures `mem_rdata` into MDR → DONE. Without ack by end of ACCESS cycle `TIMEOUT`: set `err`, MDR unchanged → DONE.
- DONE: `mem_req`=0, `done`=1 for one cycle → IDLE.
- While busy: `ld_mar`, `ld_mdr`, `rd_req`, `wr_req` ignored; MAR/MDR frozen except the read capture.
- `mem_ack` outside ACCESS ignored.
- `MDA_out`/`MDM_out` combinational from `*_oe` and MDR, in every state; both enables may be high together. Zero when disabled (buses are OR-combined).
- `err` holds until the next accepted request or reset.
- Reset mid-transaction: immediately IDLE, `mem_req` drops asynchronously, MDR = 0.

## Timing
- Load in the same cycle as a request: the register updates at the edge, so the transaction uses the new value.
- Zero-wait read: `rd_req` at edge 0 → ACCESS in cycle 1; ack in cycle 1 → `done`=1 and MDR valid in cycle 2; next request accepted from cycle 3.
- N wait states add N cycles. Ack on ACCESS cycle `TIMEOUT` is still accepted.
- `mem_req` is registered-state-decoded and glitch-free. `done`, `busy`, `err` are registered/state-decoded.

## Structure
- Package `mau_pkg`: state enum (IDLE, ACCESS, DONE), op encoding (RD=0, WR=1), width localparams.
- Timeout counter width is $clog2(TIMEOUT+1).
- Flat module, no sub-module; an inline counter is sufficient.

## Test plan
- Reset: hold `rst_n`=0 with `mda_oe`=`mdm_oe`=1 → both outputs 0x0000, `mem_req`=0; release and load MDR=0xA5A5 → `MDA_out`=0xA5A5 only while `mda_oe`.
- Zero-wait read: MAR=0x0010, `rd_req`, ack in the same cycle as `mem_req` with rdata 0x1234 → `done` in cycle 2, MDR=0x1234, `err`=0.
- Write with 3 wait states: MAR=0x00FF, MDR=0xBEEF, `wr_req` → `mem_req` high 4 cycles with `mem_we`=1, addr 0x00FF, wdata 0xBEEF; `done` in the cycle after ack.
- Timeout: `rd_req`, no ack → `mem_req` high exactly 15 cycles, then `done`+`err`, MDR unchanged. Next valid request clears `err`.
- Collisions: `rd_req`&`wr_req` together → no `mem_req`, `err`=1. `ld_mdr`=0x7777 during ACCESS → MDR unchanged. Same-cycle `ld_mar`=0x0042 + `rd_req` → `mem_addr`=0x0042.
- Reset asserted in cycle 2 of a 5-wait read → `mem_req` falls without a clock edge; after release state is IDLE, MDR=0.
